// File: rtl/alu_exec_responder.sv
// Valid/ready ALU responder: single-cycle simple ops, W-cycle shift-add MUL.
// Optional Carry output when ALU_CARRY_EN is defined.
package Definitions;
    typedef enum logic [4:0] {
        ADD = 5'd0,
        SUB = 5'd1,
        AND = 5'd2,
        OR  = 5'd3,
        XOR = 5'd4,
        CMP = 5'd5,
        SHL = 5'd6,
        SHR = 5'd7,
        MUL = 5'd8
    } opcode_e;
endpackage

module alu_exec_responder
    import Definitions::*;
#(
    parameter int W   = 8,
    parameter int Ops = 5
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           ReqValid,
    output logic           ReqReady,
    input  logic [Ops-1:0] OP,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    output logic           RespValid,
    input  logic           RespReady,
    output logic [W-1:0]   Out,
    output logic           Zero,
    output logic           Illegal
`ifdef ALU_CARRY_EN
    ,
    output logic           Carry
`endif
);

    localparam int SW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   out_q, out_d;
    logic           zero_q, zero_d;
    logic           illegal_q, illegal_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mca_q, mca_d;
    logic [W-1:0]   mcb_q, mcb_d;
    logic [W-1:0]   alu_res;
    logic           alu_ill;
    logic [SW-1:0]  shamt;
    logic [W-1:0]   mul_sum;
    logic           accept;
`ifdef ALU_CARRY_EN
    logic           carry_q, carry_d;
    logic           alu_cy;
`endif

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        shamt   = InputB[SW-1:0];
`ifdef ALU_CARRY_EN
        alu_cy  = 1'b0;
`endif
        case (OP)
            ADD: begin
`ifdef ALU_CARRY_EN
                {alu_cy, alu_res} = {1'b0, InputA} + {1'b0, InputB};
`else
                alu_res = InputA + InputB;
`endif
            end
            SUB, CMP: begin
                alu_res = InputA - InputB;
`ifdef ALU_CARRY_EN
                alu_cy  = (InputA < InputB);
`endif
            end
            AND:     alu_res = InputA & InputB;
            OR:      alu_res = InputA | InputB;
            XOR:     alu_res = InputA ^ InputB;
            SHL:     alu_res = InputA << shamt;
            SHR:     alu_res = InputA >> shamt;
            MUL:     alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // One shift-add step: partial product of the current multiplier LSB.
    assign mul_sum = acc_q + (mcb_q[0] ? mca_q : '0);

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mca_d     = mca_q;
        mcb_d     = mcb_q;
`ifdef ALU_CARRY_EN
        carry_d   = carry_q;
`endif
        accept    = 1'b0;
        ReqReady  = 1'b0;
        RespValid = 1'b0;

        case (state_q)
            S_IDLE: begin
                ReqReady = 1'b1;
                accept   = ReqValid;
            end
            S_MUL: begin
                acc_d = mul_sum;
                mca_d = mca_q << 1;
                mcb_d = mcb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(W - 1)) begin
                    state_d   = S_RESP;
                    out_d     = mul_sum;
                    zero_d    = (mul_sum == '0);
                    illegal_d = 1'b0;
`ifdef ALU_CARRY_EN
                    carry_d   = 1'b0;
`endif
                end
            end
            S_RESP: begin
                RespValid = 1'b1;
                ReqReady  = RespReady;
                if (RespReady) begin
                    state_d = S_IDLE;
                    accept  = ReqValid;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new accept overrides the state chosen above (same-edge handoff from RESP).
        if (accept) begin
            if (OP == MUL) begin
                state_d = S_MUL;
                cnt_d   = '0;
                acc_d   = '0;
                mca_d   = InputA;
                mcb_d   = InputB;
            end else begin
                state_d   = S_RESP;
                out_d     = alu_res;
                zero_d    = !alu_ill && (alu_res == '0);
                illegal_d = alu_ill;
`ifdef ALU_CARRY_EN
                carry_d   = alu_cy;
`endif
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            out_q     <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mca_q     <= '0;
            mcb_q     <= '0;
`ifdef ALU_CARRY_EN
            carry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mca_q     <= mca_d;
            mcb_q     <= mcb_d;
`ifdef ALU_CARRY_EN
            carry_q   <= carry_d;
`endif
        end
    end

    assign Out     = out_q;
    assign Zero    = zero_q;
    assign Illegal = illegal_q;
`ifdef ALU_CARRY_EN
    assign Carry   = carry_q;
`endif

endmodule

// File: tb/tb_alu_exec_responder.sv
// Directed self-checking bench for alu_exec_responder (W=8).
module tb_alu_exec_responder;
    import Definitions::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       ReqValid;
    logic       ReqReady;
    logic [4:0] OP;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic       RespValid;
    logic       RespReady;
    logic [7:0] Out;
    logic       Zero;
    logic       Illegal;
`ifdef ALU_CARRY_EN
    logic       Carry;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    alu_exec_responder #(.W(8), .Ops(5)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .OP        (OP),
        .InputA    (InputA),
        .InputB    (InputB),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .Out       (Out),
        .Zero      (Zero),
        .Illegal   (Illegal)
`ifdef ALU_CARRY_EN
        ,
        .Carry     (Carry)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_carry(input string tag, input logic exp);
`ifdef ALU_CARRY_EN
        check(tag, 32'(Carry), 32'(exp));
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       cy;
    } vec_t;

    vec_t stream [8];

    initial begin
        stream[0] = '{SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1};
        stream[1] = '{AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        stream[2] = '{OR,  8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0};
        stream[3] = '{XOR, 8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0};
        stream[4] = '{SHR, 8'h80, 8'h0B, 8'h10, 1'b0, 1'b0};
        stream[5] = '{SHL, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0};
        stream[6] = '{ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
        stream[7] = '{CMP, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0};

        Reset = 1'b1; ReqValid = 1'b0; RespReady = 1'b0;
        OP = '0; InputA = '0; InputB = '0;
        tick(); tick();
        Reset = 1'b0;
        tick();

        // Idle after reset
        check("rst_respvalid", 32'(RespValid), 32'd0);
        check("rst_reqready",  32'(ReqReady),  32'd1);
        check("rst_out",       32'(Out),       32'h00);
        check("rst_zero",      32'(Zero),      32'd0);
        check("rst_illegal",   32'(Illegal),   32'd0);
        check_carry("rst_carry", 1'b0);

        // ADD wraps to zero
        RespReady = 1'b1;
        ReqValid = 1'b1; OP = ADD; InputA = 8'hFF; InputB = 8'h01;
        tick();
        ReqValid = 1'b0;
        check("add_respvalid", 32'(RespValid), 32'd1);
        check("add_out",       32'(Out),       32'h00);
        check("add_zero",      32'(Zero),      32'd1);
        check("add_illegal",   32'(Illegal),   32'd0);
        check_carry("add_carry", 1'b1);
        tick();
        check("add_done", 32'(RespValid), 32'd0);

        // CMP equal, then CMP less-than back-to-back
        ReqValid = 1'b1; OP = CMP; InputA = 8'h01; InputB = 8'h01;
        tick();
        check("cmpeq_out",  32'(Out),  32'h00);
        check("cmpeq_zero", 32'(Zero), 32'd1);
        check_carry("cmpeq_carry", 1'b0);
        OP = CMP; InputA = 8'h01; InputB = 8'h02;
        tick();
        ReqValid = 1'b0;
        check("cmplt_respvalid", 32'(RespValid), 32'd1);
        check("cmplt_out",       32'(Out),       32'hFF);
        check("cmplt_zero",      32'(Zero),      32'd0);
        check_carry("cmplt_carry", 1'b1);
        tick();

        // MUL latency and result
        ReqValid = 1'b1; OP = MUL; InputA = 8'h0D; InputB = 8'h0B;
        tick();
        ReqValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("mul_busy_reqready%0d", i),  32'(ReqReady),  32'd0);
            check($sformatf("mul_busy_respvalid%0d", i), 32'(RespValid), 32'd0);
            tick();
        end
        check("mul_respvalid", 32'(RespValid), 32'd1);
        check("mul_out",       32'(Out),       32'h8F);
        check("mul_zero",      32'(Zero),      32'd0);
        check("mul_illegal",   32'(Illegal),   32'd0);
        check_carry("mul_carry", 1'b0);
        tick();
        check("mul_done", 32'(RespValid), 32'd0);

        // SHL response stalled, queued ADD handed off on the same edge
        RespReady = 1'b0;
        ReqValid = 1'b1; OP = SHL; InputA = 8'h81; InputB = 8'h01;
        tick();
        OP = ADD; InputA = 8'h03; InputB = 8'h04;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_respvalid%0d", i), 32'(RespValid), 32'd1);
            check($sformatf("stall_out%0d", i),       32'(Out),       32'h02);
            check($sformatf("stall_reqready%0d", i),  32'(ReqReady),  32'd0);
            tick();
        end
        RespReady = 1'b1;
        #1;
        check("handoff_reqready", 32'(ReqReady), 32'd1);
        tick();
        ReqValid = 1'b0;
        check("handoff_respvalid", 32'(RespValid), 32'd1);
        check("handoff_out",       32'(Out),       32'h07);
        check("handoff_zero",      32'(Zero),      32'd0);
        tick();
        check("handoff_done", 32'(RespValid), 32'd0);

        // Reset in the middle of a MUL drops it
        ReqValid = 1'b1; OP = MUL; InputA = 8'h0D; InputB = 8'h0B;
        tick();
        ReqValid = 1'b0;
        tick(); tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midrst_respvalid", 32'(RespValid), 32'd0);
        check("midrst_reqready",  32'(ReqReady),  32'd1);
        check("midrst_out",       32'(Out),       32'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("midrst_quiet%0d", i), 32'(RespValid), 32'd0);
        end

        // Unlisted opcode
        ReqValid = 1'b1; OP = 5'h1F; InputA = 8'h12; InputB = 8'h34;
        tick();
        ReqValid = 1'b0;
        check("ill_respvalid", 32'(RespValid), 32'd1);
        check("ill_illegal",   32'(Illegal),   32'd1);
        check("ill_out",       32'(Out),       32'h00);
        check("ill_zero",      32'(Zero),      32'd0);
        tick();

        // Back-to-back stream, one op per cycle
        for (int i = 0; i < 8; i++) begin
            ReqValid = 1'b1; OP = stream[i].op; InputA = stream[i].a; InputB = stream[i].b;
            tick();
            check($sformatf("stream_valid%0d", i), 32'(RespValid), 32'd1);
            check($sformatf("stream_out%0d", i),   32'(Out),       32'(stream[i].res));
            check($sformatf("stream_zero%0d", i),  32'(Zero),      32'(stream[i].z));
            check_carry($sformatf("stream_carry%0d", i), stream[i].cy);
        end
        ReqValid = 1'b0;
        tick();
        check("stream_done", 32'(RespValid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
